mux_sel_sequencer: RTL and testbench

MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

---
 rtl/mux_sel_pkg.sv | 23 ++
 rtl/mux_sel_next.sv | 43 ++++
 rtl/mux_sel_sequencer.sv | 78 +++++++
 tb/tb_mux_sel_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared constants and helpers for the mux select sequencer.
// Optional feature macro: MUX_SEL_CH_MASK_EN (honour ch_mask when defined).
package mux_sel_pkg;

   // Largest supported channel count.
   localparam int unsigned N_CH_MAX = 16;

   // Ceiling log2, used to size the select bus.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 0;
      while ((32'd1 << w) < n) begin
         w++;
      end
      return w;
   endfunction

   // Reset select: the top channel, so the first advance lands on channel 0.
   function automatic int unsigned default_init_sel(input int unsigned n_ch);
      return n_ch - 1;
   endfunction

endpackage

// File: rtl/mux_sel_next.sv
// Combinational next-channel search for the mux select sequencer.
// Searches upward from cur+1 modulo N_CH and checks cur itself last.
// Reports the first enabled channel, whether any was found, and whether
// the result wrapped (result <= cur).
module mux_sel_next
   import mux_sel_pkg::*;
#(
   parameter int unsigned N_CH  = 8,
   parameter int unsigned SEL_W = clog2(N_CH)
) (
   input  logic [SEL_W-1:0] cur,
   input  logic [N_CH-1:0]  mask,
   output logic [SEL_W-1:0] nxt,
   output logic             found,
   output logic             wrapped
);

   // One spare bit so cur+k never overflows before the modulo fold.
   logic [SEL_W:0] idx;

   // Rotating priority search; offset N_CH lands back on cur, so it is checked last.
   always_comb begin
      nxt   = cur;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         idx = {1'b0, cur} + (SEL_W+1)'(k);
         if (idx >= (SEL_W+1)'(N_CH)) begin
            idx = idx - (SEL_W+1)'(N_CH);
         end
         if (!found && mask[idx[SEL_W-1:0]]) begin
            found = 1'b1;
            nxt   = idx[SEL_W-1:0];
         end
      end
   end

   // A wrap is any found result that does not move strictly upward.
   always_comb begin
      wrapped = found && (nxt <= cur);
   end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Mux select sequencer: registered select with reset > load > advance > hold.
// Optional feature macro: MUX_SEL_CH_MASK_EN. When undefined, ch_mask is
// ignored and every channel counts as enabled.
module mux_sel_sequencer
   import mux_sel_pkg::*;
#(
   parameter int unsigned N_CH     = 8,
   parameter int unsigned INIT_SEL = default_init_sel(N_CH)
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     valid_count,
   input  logic                     load,
   input  logic [clog2(N_CH)-1:0]   load_sel,
   input  logic [N_CH-1:0]          ch_mask,
   output logic [clog2(N_CH)-1:0]   CTR,
   output logic                     ctr_valid,
   output logic                     wrap
);

   localparam int unsigned SEL_W = clog2(N_CH);

   logic [N_CH-1:0]  eff_mask;
   logic [SEL_W-1:0] nxt_sel;
   logic             nxt_found;
   logic             nxt_wrap;
   logic             load_ok;

`ifdef MUX_SEL_CH_MASK_EN
   assign eff_mask = ch_mask;
`else
   logic unused_ch_mask;
   assign eff_mask       = '1;
   assign unused_ch_mask = ^ch_mask;
`endif

   // Out-of-range load selects are rejected (only reachable for non-power-of-two N_CH).
   assign load_ok = ({1'b0, load_sel} < (SEL_W+1)'(N_CH));

   mux_sel_next #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_next (
      .cur     (CTR),
      .mask    (eff_mask),
      .nxt     (nxt_sel),
      .found   (nxt_found),
      .wrapped (nxt_wrap)
   );

   // Select register with reset > load > advance > hold priority; wrap is a one-cycle pulse.
   always_ff @(posedge CLK) begin
      if (reset) begin
         CTR       <= SEL_W'(INIT_SEL);
         ctr_valid <= 1'b0;
         wrap      <= 1'b0;
      end else if (load) begin
         // A rejected load still wins priority, so a same-edge advance is dropped.
         wrap <= 1'b0;
         if (load_ok) begin
            CTR       <= load_sel;
            ctr_valid <= eff_mask[load_sel];
         end
      end else if (valid_count) begin
         if (nxt_found) begin
            CTR       <= nxt_sel;
            ctr_valid <= 1'b1;
            wrap      <= nxt_wrap;
         end else begin
            ctr_valid <= 1'b0;
            wrap      <= 1'b0;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer at N_CH=5 (non-power-of-two, so
// out-of-range load selects are reachable). Honours MUX_SEL_CH_MASK_EN.
module tb_mux_sel_sequencer;
   import mux_sel_pkg::*;

   localparam int unsigned N_CH  = 5;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned INIT  = 4;

   typedef struct {
      logic [SEL_W-1:0] ctr;
      logic             valid;
      logic             wrap;
      int               seq;
   } exp_t;

   logic             CLK;
   logic             reset;
   logic             valid_count;
   logic             load;
   logic [SEL_W-1:0] load_sel;
   logic [N_CH-1:0]  ch_mask;
   logic [SEL_W-1:0] CTR;
   logic             ctr_valid;
   logic             wrap;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   seq_no   = 0;

   int   m_ctr;
   bit   m_valid;
   bit   m_wrap;

   mux_sel_sequencer #(
      .N_CH (N_CH)
   ) dut (
      .CLK         (CLK),
      .reset       (reset),
      .valid_count (valid_count),
      .load        (load),
      .load_sel    (load_sel),
      .ch_mask     (ch_mask),
      .CTR         (CTR),
      .ctr_valid   (ctr_valid),
      .wrap        (wrap)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [N_CH-1:0] eff(input logic [N_CH-1:0] m);
`ifdef MUX_SEL_CH_MASK_EN
      return m;
`else
      return '1;
`endif
   endfunction

   // Drive one cycle of inputs, advance the reference model, queue the expectation.
   task automatic step(input logic r, input logic ld, input int ls,
                       input logic vc, input logic [N_CH-1:0] m);
      logic [N_CH-1:0] em;
      int above;
      int lowest;
      exp_t e;
      @(negedge CLK);
      reset       = r;
      load        = ld;
      load_sel    = SEL_W'(ls);
      valid_count = vc;
      ch_mask     = m;
      em          = eff(m);
      if (r) begin
         m_ctr = INIT; m_valid = 0; m_wrap = 0;
      end else if (ld) begin
         m_wrap = 0;
         if (ls < N_CH) begin
            m_ctr   = ls;
            m_valid = em[ls];
         end
      end else if (vc) begin
         if (em == '0) begin
            m_valid = 0; m_wrap = 0;
         end else begin
            above  = -1;
            lowest = -1;
            for (int i = 0; i < N_CH; i++) begin
               if (em[i]) begin
                  if (lowest < 0) lowest = i;
                  if (i > m_ctr && above < 0) above = i;
               end
            end
            if (above >= 0) begin
               m_ctr = above; m_wrap = 0;
            end else begin
               m_ctr = lowest; m_wrap = 1;
            end
            m_valid = 1;
         end
      end else begin
         m_wrap = 0;
      end
      e.ctr   = SEL_W'(m_ctr);
      e.valid = m_valid;
      e.wrap  = m_wrap;
      e.seq   = seq_no;
      seq_no++;
      exp_q.push_back(e);
   endtask

   // Monitor: after each active edge, compare the registered outputs with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (CTR !== e.ctr) begin
               failures++;
               $display("FAIL ctr seq=%0d got=%0d exp=%0d", e.seq, CTR, e.ctr);
            end
            checks++;
            if (ctr_valid !== e.valid) begin
               failures++;
               $display("FAIL ctr_valid seq=%0d got=%0b exp=%0b", e.seq, ctr_valid, e.valid);
            end
            checks++;
            if (wrap !== e.wrap) begin
               failures++;
               $display("FAIL wrap seq=%0d got=%0b exp=%0b", e.seq, wrap, e.wrap);
            end
            checks++;
            if (CTR >= SEL_W'(N_CH)) begin
               failures++;
               $display("FAIL ctr_range seq=%0d got=%0d max=%0d", e.seq, CTR, N_CH - 1);
            end
         end
      end
   end

   // Stimulus: directed corner cases followed by randomized traffic.
   initial begin
      logic [N_CH-1:0] rm;
      int drain;
      reset = 1'b1; load = 1'b0; load_sel = '0; valid_count = 1'b0; ch_mask = '1;
      m_ctr = INIT; m_valid = 0; m_wrap = 0;

      step(1, 0, 0, 0, 5'h1F);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 5'h1F);
      step(1, 1, 2, 1, 5'h1F);
      step(0, 0, 0, 1, 5'h1F);
      step(0, 1, 3, 1, 5'h1F);
      step(0, 1, 6, 1, 5'h1F);
      step(0, 0, 0, 0, 5'h00);
      step(0, 0, 0, 1, 5'h00);
      step(0, 1, 4, 0, 5'b10000);
      step(0, 0, 0, 1, 5'b10000);
      step(0, 0, 0, 0, 5'b00101);
      step(0, 1, 0, 0, 5'b00101);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 5'b00101);
      step(0, 1, 7, 0, 5'b00101);

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0:       rm = '0;
            1:       rm = '1;
            2:       rm = N_CH'(1) << $urandom_range(0, N_CH - 1);
            default: rm = N_CH'($urandom);
         endcase
         step(($urandom_range(0, 99) < 3),
              ($urandom_range(0, 99) < 15),
              int'($urandom_range(0, 7)),
              ($urandom_range(0, 99) < 60),
              rm);
      end

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(negedge CLK);
         drain++;
      end
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
